// File: rtl/mem_responder_pkg.sv
// Shared typedefs and default sizing for the memory responder and the CPU datapath.
// Contents:
//   AWIDTH_DEF / DWIDTH_DEF / FIFO_DEPTH_DEF / IO_ADDR_DEF  default geometry
//   respStateT                                           responder FSM states
//   count_width()                                        width of a FIFO occupancy count
package mem_responder_pkg;

    localparam int unsigned AWIDTH_DEF     = 5;
    localparam int unsigned DWIDTH_DEF     = 8;
    localparam int unsigned FIFO_DEPTH_DEF = 4;
    localparam logic [AWIDTH_DEF-1:0] IO_ADDR_DEF = '1;

    typedef enum logic [1:0] {
        LOAD,
        RUN,
        HALTED
    } respStateT;

    // Occupancy needs one bit more than the pointer index so "full" is representable.
    function automatic int unsigned count_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/mem_responder_if.sv
// Bus bundle between the CPU/loader/consumer side (master) and mem_responder (slave).
// Signals:
//   CPU bus : addr, memRd, memWr, halt, wdata -> ; <- rdata, cpu_rst_, bus_err
//   Loader  : ld_valid, ld_addr, ld_data, ld_done -> ; <- ld_ready
//   IO port : io_ready -> ; <- io_valid, io_data, io_ovf
interface mem_responder_if
    import mem_responder_pkg::*;
#(
    parameter int unsigned AWIDTH = AWIDTH_DEF,
    parameter int unsigned DWIDTH = DWIDTH_DEF
) ();

    logic [AWIDTH-1:0] addr;
    logic              memRd;
    logic              memWr;
    logic              halt;
    logic [DWIDTH-1:0] wdata;
    logic [DWIDTH-1:0] rdata;
    logic              cpu_rst_;

    logic              ld_valid;
    logic              ld_ready;
    logic [AWIDTH-1:0] ld_addr;
    logic [DWIDTH-1:0] ld_data;
    logic              ld_done;

    logic              io_valid;
    logic              io_ready;
    logic [DWIDTH-1:0] io_data;
    logic              io_ovf;
    logic              bus_err;

    modport master (
        output addr, memRd, memWr, halt, wdata,
        output ld_valid, ld_addr, ld_data, ld_done,
        output io_ready,
        input  rdata, cpu_rst_, ld_ready, io_valid, io_data, io_ovf, bus_err
    );

    modport slave (
        input  addr, memRd, memWr, halt, wdata,
        input  ld_valid, ld_addr, ld_data, ld_done,
        input  io_ready,
        output rdata, cpu_rst_, ld_ready, io_valid, io_data, io_ovf, bus_err
    );

endinterface

// File: rtl/mem_responder_io_fifo.sv
// io_fifo: small output FIFO behind the memory-mapped IO address.
// Ports:
//   clk, rst   clock, async active-high reset (clears pointers and storage)
//   push       write push_data (ignored when full unless a pop happens on the same edge)
//   push_data  word to enqueue
//   full       DEPTH words held
//   pop        dequeue head (ignored when empty)
//   empty      no words held
//   count      occupancy, 0..DEPTH
//   data       head word (combinational from storage)
module io_fifo #(
    parameter int unsigned DWIDTH = 8,
    parameter int unsigned DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [DWIDTH-1:0]        push_data,
    output logic                     full,
    input  logic                     pop,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic [DWIDTH-1:0]        data
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam logic [PW:0] PTR_ONE = {{PW{1'b0}}, 1'b1};

    logic [DWIDTH-1:0] store [DEPTH];
    logic [PW:0]       wr_ptr;
    logic [PW:0]       rd_ptr;
    logic              pop_ok;
    logic              push_ok;

    // Extra pointer MSB distinguishes full (MSBs differ) from empty (all equal).
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
    assign count   = wr_ptr - rd_ptr;
    assign data    = store[rd_ptr[PW-1:0]];

    // A pop on the same edge frees the slot, so a push into a full FIFO still lands.
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                store[i] <= '0;
            end
        end else begin
            if (push_ok) begin
                store[wr_ptr[PW-1:0]] <= push_data;
                wr_ptr                <= wr_ptr + PTR_ONE;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
        end
    end

endmodule

// File: rtl/mem_responder.sv
// mem_responder: memory-side responder for the CPU's memRd/memWr strobes.
// Holds program/data RAM (registered 1-cycle read), an output FIFO mapped at IO_ADDR,
// and the loader handshake that keeps the CPU in reset until the program is loaded.
// Ports:
//   clk   clock, rising edge
//   rst   async active-high reset (RAM contents are kept)
//   bus   mem_responder_if.slave: CPU bus, loader handshake, IO FIFO port, sticky flags
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int unsigned       AWIDTH     = AWIDTH_DEF,
    parameter int unsigned       DWIDTH     = DWIDTH_DEF,
    parameter logic [AWIDTH-1:0] IO_ADDR    = '1,
    parameter int unsigned       FIFO_DEPTH = FIFO_DEPTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    mem_responder_if.slave        bus
);

    localparam int unsigned CW = count_width(FIFO_DEPTH);

    respStateT         state;
    logic [DWIDTH-1:0] mem [2**AWIDTH];

    logic [DWIDTH-1:0] rdata_q;
    logic              cpu_rst_q;
    logic              ld_ready_q;
    logic              io_ovf_q;
    logic              bus_err_q;

    logic              io_hit;
    logic              ram_we;
    logic [AWIDTH-1:0] ram_waddr;
    logic [DWIDTH-1:0] ram_wdata;

    logic              fifo_push;
    logic              fifo_pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [CW-1:0]     fifo_count;
    logic [DWIDTH-1:0] fifo_data;

    assign io_hit    = (bus.addr == IO_ADDR);
    assign fifo_push = (state == RUN) && bus.memWr && io_hit;
    assign fifo_pop  = !fifo_empty && bus.io_ready;

    // Single RAM write port shared by the loader (LOAD) and the CPU (RUN).
    always_comb begin
        ram_we    = 1'b0;
        ram_waddr = '0;
        ram_wdata = '0;
        if (state == LOAD) begin
            if (bus.ld_valid && ld_ready_q && (bus.ld_addr != IO_ADDR)) begin
                ram_we    = 1'b1;
                ram_waddr = bus.ld_addr;
                ram_wdata = bus.ld_data;
            end
        end else if (state == RUN) begin
            if (bus.memWr && !io_hit) begin
                ram_we    = 1'b1;
                ram_waddr = bus.addr;
                ram_wdata = bus.wdata;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (ram_we) begin
            mem[ram_waddr] <= ram_wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= LOAD;
            rdata_q    <= '0;
            cpu_rst_q  <= 1'b0;
            ld_ready_q <= 1'b1;
            io_ovf_q   <= 1'b0;
            bus_err_q  <= 1'b0;
        end else begin
            case (state)
                LOAD: begin
                    cpu_rst_q  <= 1'b0;
                    ld_ready_q <= 1'b1;
                    if (bus.ld_done) begin
                        state      <= RUN;
                        ld_ready_q <= 1'b0;
                    end
                end
                RUN: begin
                    cpu_rst_q  <= 1'b1;
                    ld_ready_q <= 1'b0;
                    if (bus.halt) begin
                        state <= HALTED;
                    end
                end
                HALTED: begin
                    cpu_rst_q  <= 1'b1;
                    ld_ready_q <= 1'b0;
                end
                default: begin
                    state <= LOAD;
                end
            endcase

            if (state != LOAD) begin
                if (bus.memRd && bus.memWr) begin
                    bus_err_q <= 1'b1;
                end else if (bus.memRd) begin
                    // IO address reads back FIFO occupancy, MSB-aligned in the data word.
                    rdata_q <= io_hit ? (DWIDTH'(fifo_count) << (DWIDTH - CW)) : mem[bus.addr];
                end
            end

            if (fifo_push && fifo_full && !fifo_pop) begin
                io_ovf_q <= 1'b1;
            end
        end
    end

    io_fifo #(
        .DWIDTH (DWIDTH),
        .DEPTH  (FIFO_DEPTH)
    ) u_io_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_data (bus.wdata),
        .full      (fifo_full),
        .pop       (fifo_pop),
        .empty     (fifo_empty),
        .count     (fifo_count),
        .data      (fifo_data)
    );

    assign bus.rdata    = rdata_q;
    assign bus.cpu_rst_ = cpu_rst_q;
    assign bus.ld_ready = ld_ready_q;
    assign bus.io_valid = !fifo_empty;
    assign bus.io_data  = fifo_data;
    assign bus.io_ovf   = io_ovf_q;
    assign bus.bus_err  = bus_err_q;

endmodule

// File: tb/tb_mem_responder.sv
module tb_mem_responder;

    localparam int unsigned IOA = 31;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    mem_responder_if #(.AWIDTH(5), .DWIDTH(8)) bus ();

    mem_responder #(
        .AWIDTH     (5),
        .DWIDTH     (8),
        .IO_ADDR    (5'h1F),
        .FIFO_DEPTH (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int passed = 0;
    int total  = 0;

    // Reference model: phase 0=loading, 1=running, 2=halted
    logic [7:0] m_mem [32];
    logic [7:0] m_q [$];
    int         m_phase;
    logic [7:0] m_rdata;
    bit         m_ovf, m_err, m_cpu_on, m_ldr;

    typedef struct {
        bit         rd;
        bit         wr;
        logic [4:0] addr;
        logic [7:0] wdata;
        bit         rdy;
        logic [7:0] e_rdata;
        bit         e_valid;
        logic [7:0] e_data;
        bit         e_ovf;
    } vec_t;

    vec_t vt [13];

    task automatic chk(input string name, input int unsigned act, input int unsigned exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic model_reset();
        m_phase  = 0;
        m_q.delete();
        m_rdata  = 8'h00;
        m_ovf    = 1'b0;
        m_err    = 1'b0;
        m_cpu_on = 1'b0;
        m_ldr    = 1'b1;
    endtask

    task automatic idle();
        bus.addr = '0; bus.memRd = 0; bus.memWr = 0; bus.halt = 0; bus.wdata = '0;
        bus.ld_valid = 0; bus.ld_addr = '0; bus.ld_data = '0; bus.ld_done = 0;
        bus.io_ready = 0;
    endtask

    task automatic compare_all();
        chk("rdata", bus.rdata, m_rdata);
        chk("cpu_rst_", bus.cpu_rst_, m_cpu_on);
        chk("ld_ready", bus.ld_ready, m_ldr);
        chk("io_valid", bus.io_valid, (m_q.size() > 0));
        if (m_q.size() > 0) chk("io_data", bus.io_data, m_q[0]);
        chk("io_ovf", bus.io_ovf, m_ovf);
        chk("bus_err", bus.bus_err, m_err);
    endtask

    // Advance one clock: model consumes the inputs present before the edge.
    task automatic cycle();
        int p;
        bit do_pop;
        p = m_phase;
        do_pop = (m_q.size() > 0) && bus.io_ready;
        if (p == 0) begin
            if (bus.ld_valid && bus.ld_addr != IOA) m_mem[bus.ld_addr] = bus.ld_data;
            if (bus.ld_done) m_phase = 1;
        end else begin
            if (bus.memRd && bus.memWr) m_err = 1'b1;
            else if (bus.memRd)
                m_rdata = (bus.addr == IOA) ? 8'(m_q.size() * 32) : m_mem[bus.addr];
        end
        if (do_pop) void'(m_q.pop_front());
        if (p == 1 && bus.memWr) begin
            if (bus.addr == IOA) begin
                if (m_q.size() < 4) m_q.push_back(bus.wdata);
                else m_ovf = 1'b1;
            end else begin
                m_mem[bus.addr] = bus.wdata;
            end
        end
        if (p == 1 && bus.halt) m_phase = 2;
        m_cpu_on = (p != 0);
        m_ldr    = (m_phase == 0);
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic random_ops(input int n);
        for (int i = 0; i < n; i++) begin
            bus.memRd    = 1'($urandom_range(0, 1));
            bus.memWr    = ($urandom_range(0, 3) == 0);
            bus.addr     = ($urandom_range(0, 3) == 0) ? 5'd31 : 5'($urandom_range(0, 30));
            if (bus.memWr && bus.addr < 4) bus.addr = bus.addr + 5'd4;
            bus.wdata    = 8'($urandom);
            bus.io_ready = ($urandom_range(0, 2) == 0);
            cycle();
        end
        idle();
    endtask

    initial begin
        logic [7:0] old3;

        vt[0]  = '{0, 1, 31, 8'hA5, 0, 8'h02, 1, 8'hA5, 0};
        vt[1]  = '{0, 1, 31, 8'h5A, 0, 8'h02, 1, 8'hA5, 0};
        vt[2]  = '{1, 0, 31, 8'h00, 0, 8'h40, 1, 8'hA5, 0};
        vt[3]  = '{0, 1, 31, 8'h11, 0, 8'h40, 1, 8'hA5, 0};
        vt[4]  = '{0, 1, 31, 8'h22, 0, 8'h40, 1, 8'hA5, 0};
        vt[5]  = '{0, 1, 31, 8'h77, 1, 8'h40, 1, 8'h5A, 0};
        vt[6]  = '{1, 0, 31, 8'h00, 0, 8'h80, 1, 8'h5A, 0};
        vt[7]  = '{0, 1, 31, 8'h33, 0, 8'h80, 1, 8'h5A, 1};
        vt[8]  = '{0, 0, 0,  8'h00, 1, 8'h80, 1, 8'h11, 1};
        vt[9]  = '{0, 0, 0,  8'h00, 1, 8'h80, 1, 8'h22, 1};
        vt[10] = '{0, 0, 0,  8'h00, 1, 8'h80, 1, 8'h77, 1};
        vt[11] = '{0, 0, 0,  8'h00, 1, 8'h80, 0, 8'h00, 1};
        vt[12] = '{1, 0, 31, 8'h00, 0, 8'h00, 0, 8'h00, 1};

        idle();
        #2 rst = 1'b1;
        #1;
        model_reset();
        chk("rst_rdata", bus.rdata, 0);
        chk("rst_cpu_rst_", bus.cpu_rst_, 0);
        chk("rst_ld_ready", bus.ld_ready, 1);
        chk("rst_io_valid", bus.io_valid, 0);
        chk("rst_io_data", bus.io_data, 0);
        chk("rst_io_ovf", bus.io_ovf, 0);
        chk("rst_bus_err", bus.bus_err, 0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;

        // Program load; CPU strobes during LOAD must be ignored.
        for (int a = 0; a < 30; a++) begin
            bus.ld_valid = 1;
            bus.ld_addr  = 5'(a);
            bus.ld_data  = (a == 0) ? 8'h01 : (a == 1) ? 8'h02 : 8'($urandom);
            bus.memRd    = (a == 5);
            bus.memWr    = (a == 5);
            bus.addr     = 5'd7;
            cycle();
        end
        idle();
        bus.ld_valid = 1; bus.ld_addr = 5'd31; bus.ld_data = 8'hEE;
        cycle();
        bus.ld_addr = 5'd30; bus.ld_data = 8'h3C; bus.ld_done = 1;
        cycle();
        chk("load_ld_ready_drop", bus.ld_ready, 0);
        chk("load_cpu_still_rst", bus.cpu_rst_, 0);
        idle();
        cycle();
        chk("load_cpu_released", bus.cpu_rst_, 1);

        // Registered read with memRd held two cycles, then hold.
        bus.addr = 5'd1; bus.memRd = 1;
        cycle();
        chk("read_first_edge", bus.rdata, 8'h02);
        cycle();
        chk("read_second_edge", bus.rdata, 8'h02);
        bus.memRd = 0; bus.addr = 5'd0;
        cycle();
        chk("read_hold", bus.rdata, 8'h02);

        // IO FIFO: push, count readback, full push+pop, overflow, drain.
        for (int i = 0; i < 13; i++) begin
            idle();
            bus.memRd = vt[i].rd; bus.memWr = vt[i].wr; bus.addr = vt[i].addr;
            bus.wdata = vt[i].wdata; bus.io_ready = vt[i].rdy;
            cycle();
            chk($sformatf("vec%0d_rdata", i), bus.rdata, vt[i].e_rdata);
            chk($sformatf("vec%0d_io_valid", i), bus.io_valid, vt[i].e_valid);
            if (vt[i].e_valid) chk($sformatf("vec%0d_io_data", i), bus.io_data, vt[i].e_data);
            chk($sformatf("vec%0d_io_ovf", i), bus.io_ovf, vt[i].e_ovf);
        end
        idle();

        // Simultaneous strobes: write lands, rdata holds, bus_err sticks.
        bus.memRd = 1; bus.memWr = 1; bus.addr = 5'd2; bus.wdata = 8'h99;
        cycle();
        chk("buserr_flag", bus.bus_err, 1);
        chk("buserr_rdata_hold", bus.rdata, 8'h00);
        bus.memWr = 0;
        cycle();
        chk("buserr_write_done", bus.rdata, 8'h99);
        idle();

        random_ops(400);

        // Halt: writes ignored, reads and FIFO drain continue.
        old3 = m_mem[3];
        bus.halt = 1;
        cycle();
        idle();
        bus.memWr = 1; bus.addr = 5'd3; bus.wdata = ~old3;
        cycle();
        bus.memWr = 0; bus.memRd = 1;
        cycle();
        chk("halt_mem3_kept", bus.rdata, old3);
        idle();
        random_ops(150);

        // Asynchronous reset mid-run.
        #2 rst = 1'b1;
        #1;
        model_reset();
        chk("rst2_cpu_rst_", bus.cpu_rst_, 0);
        chk("rst2_ld_ready", bus.ld_ready, 1);
        chk("rst2_rdata", bus.rdata, 0);
        chk("rst2_io_valid", bus.io_valid, 0);
        chk("rst2_io_ovf", bus.io_ovf, 0);
        chk("rst2_bus_err", bus.bus_err, 0);
        @(negedge clk) rst = 1'b0;
        bus.ld_done = 1;
        cycle();
        idle();
        bus.memRd = 1; bus.addr = 5'd0;
        cycle();
        chk("rst2_mem0_retained", bus.rdata, 8'h01);
        idle();
        cycle();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
